// File: rtl/event_log_pkg.sv
// Shared constants for the event log: default geometry, drop-counter limits, entry layout.
package event_log_pkg;

  localparam int unsigned WIDTH_DEF    = 32;
  localparam int unsigned DEPTH_DEF    = 16;
  localparam int unsigned TS_WIDTH_DEF = 16;

  localparam int unsigned DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_SAT = DROP_W'(255);

  // Stored entry is {event word, timestamp}: event in the high field, timestamp low.
  localparam int unsigned ENTRY_W_DEF = WIDTH_DEF + TS_WIDTH_DEF;

  function automatic int unsigned entry_w(input int unsigned ev_w, input int unsigned ts_w);
    return ev_w + ts_w;
  endfunction

endpackage

// File: rtl/event_log_if.sv
// Monitor/host-facing bundle of the event log: capture controls in, FIFO head and status out.
interface event_log_if import event_log_pkg::*; #(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned TS_WIDTH = TS_WIDTH_DEF
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                enable;
  logic                clear;
  logic [WIDTH-1:0]    i_event;
  logic                i_pop;
  logic                o_valid;
  logic [WIDTH-1:0]    o_event;
  logic [TS_WIDTH-1:0] o_timestamp;
  logic [CW-1:0]       o_count;
  logic                o_full;
  logic                o_empty;
  logic [DROP_W-1:0]   o_drop_ctr;

  modport master (
    output enable, clear, i_event, i_pop,
    input  o_valid, o_event, o_timestamp, o_count, o_full, o_empty, o_drop_ctr
  );

  modport slave (
    input  enable, clear, i_event, i_pop,
    output o_valid, o_event, o_timestamp, o_count, o_full, o_empty, o_drop_ctr
  );

endinterface

// File: rtl/event_log_sync_fifo.sv
// Single-clock show-ahead FIFO with a separately tracked occupancy count.
module event_log_sync_fifo import event_log_pkg::*; #(
  parameter int unsigned DW    = ENTRY_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              wdata,
  output logic [DW-1:0]              rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_eff;
  logic          pop_eff;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  always_comb begin
    push_eff = 1'b0;
    pop_eff  = 1'b0;
    if (!clr) begin
      pop_eff  = pop && !empty;
      push_eff = push && (!full || pop_eff);
    end
  end

  // Pointers and occupancy; clear wins over any traffic in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are left stale on clear since the count masks them.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= wdata;
  end

  // Head is shown combinationally and forced to zero while empty.
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/event_log.sv
// Timestamped capture of non-zero monitor event words into a show-ahead FIFO.
module event_log import event_log_pkg::*; #(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned TS_WIDTH = TS_WIDTH_DEF
) (
  input  logic      clk,
  input  logic      reset,
  event_log_if.slave bus
);

  localparam int unsigned EW = entry_w(WIDTH, TS_WIDTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [TS_WIDTH-1:0] ts;
  logic [DROP_W-1:0]   drop_ctr;
  logic                push_req;
  logic                drop;
  logic [EW-1:0]       wdata;
  logic [EW-1:0]       rdata;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;

  assign push_req = bus.enable && (bus.i_event != '0);
  assign wdata    = {bus.i_event, ts};
  // A full FIFO loses the event unless the head is popped in the same cycle.
  assign drop     = push_req && full && !bus.i_pop;

  event_log_sync_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clr   (bus.clear),
    .push  (push_req),
    .pop   (bus.i_pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Free-running timestamp, advancing only while capture is enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts <= '0;
    end else if (bus.clear) begin
      ts <= '0;
    end else if (bus.enable) begin
      ts <= ts + TS_WIDTH'(1);
    end
  end

  // Saturating count of events lost to a full FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_ctr <= '0;
    end else if (bus.clear) begin
      drop_ctr <= '0;
    end else if (drop && (drop_ctr != DROP_SAT)) begin
      drop_ctr <= drop_ctr + DROP_W'(1);
    end
  end

  assign bus.o_valid     = !empty;
  assign bus.o_event     = rdata[EW-1 -: WIDTH];
  assign bus.o_timestamp = rdata[TS_WIDTH-1:0];
  assign bus.o_count     = count;
  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_drop_ctr  = drop_ctr;

endmodule

// File: tb/tb_event_log.sv
// Self-checking bench for event_log: directed scenarios plus a randomized run against a queue model.
module tb_event_log;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  event_log_if #(.WIDTH(32), .DEPTH(16), .TS_WIDTH(16)) bus ();
  event_log_if #(.WIDTH(32), .DEPTH(4),  .TS_WIDTH(4))  bus4 ();

  event_log #(.WIDTH(32), .DEPTH(16), .TS_WIDTH(16)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  event_log #(.WIDTH(32), .DEPTH(4), .TS_WIDTH(4)) u_dut4 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus4)
  );

  typedef struct {
    logic [31:0] ev;
    logic [15:0] ts;
  } ent_t;

  ent_t q[$];
  int   m_ts;
  int   m_drop;
  int   n_cmp;
  int   n_fail;

  // Reference model of one clock edge for the 16-deep, 16-bit-timestamp instance.
  task automatic model_edge();
    bit   popped;
    ent_t e;
    if (bus.clear) begin
      q.delete();
      m_ts   = 0;
      m_drop = 0;
      return;
    end
    popped = bus.i_pop && (q.size() > 0);
    if (bus.enable && (bus.i_event != 32'd0)) begin
      e.ev = bus.i_event;
      e.ts = 16'(m_ts);
      if (popped) void'(q.pop_front());
      if (q.size() < 16) q.push_back(e);
      else if (m_drop < 255) m_drop++;
    end else if (popped) begin
      void'(q.pop_front());
    end
    if (bus.enable) m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.enable  = 1'b0;
    bus.clear   = 1'b0;
    bus.i_event = '0;
    bus.i_pop   = 1'b0;
    bus4.enable  = 1'b0;
    bus4.clear   = 1'b0;
    bus4.i_event = '0;
    bus4.i_pop   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    q.delete();
    m_ts   = 0;
    m_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle_inputs();
    #2;
    do_reset();
    n_cmp++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b exp 1", bus.o_empty); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b exp 0", bus.o_valid); end
    n_cmp++; if (bus.o_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", bus.o_count); end
    n_cmp++; if (bus.o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b exp 0", bus.o_full); end
    n_cmp++; if (bus.o_drop_ctr !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d exp 0", bus.o_drop_ctr); end
    n_cmp++; if ({bus.o_event, bus.o_timestamp} !== 48'd0) begin n_fail++; $display("FAIL reset_head: got %0h exp 0", {bus.o_event, bus.o_timestamp}); end
  endtask

  task automatic test_idle_ts();
    do_reset();
    bus.enable = 1'b1;
    repeat (10) tick();
    n_cmp++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL idle_empty: got %0b exp 1", bus.o_empty); end
    n_cmp++; if (bus.o_count !== 5'd0) begin n_fail++; $display("FAIL idle_count: got %0d exp 0", bus.o_count); end
    bus.i_event = 32'h1234;
    tick();
    bus.i_event = '0;
    n_cmp++; if (bus.o_timestamp !== 16'd10) begin n_fail++; $display("FAIL idle_ts: got %0d exp 10", bus.o_timestamp); end
  endtask

  task automatic test_single_event();
    do_reset();
    bus.enable = 1'b1;
    repeat (3) tick();
    bus.i_event = 32'h5;
    tick();
    bus.i_event = '0;
    n_cmp++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b exp 1", bus.o_valid); end
    n_cmp++; if (bus.o_event !== 32'h5) begin n_fail++; $display("FAIL single_event: got %0h exp 5", bus.o_event); end
    n_cmp++; if (bus.o_timestamp !== 16'd3) begin n_fail++; $display("FAIL single_ts: got %0d exp 3", bus.o_timestamp); end
    bus.i_pop = 1'b1;
    tick();
    bus.i_pop = 1'b0;
    n_cmp++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL single_pop_empty: got %0b exp 1", bus.o_empty); end
    bus.i_pop = 1'b1;
    tick();
    bus.i_pop = 1'b0;
    n_cmp++; if (bus.o_count !== 5'd0) begin n_fail++; $display("FAIL underflow_count: got %0d exp 0", bus.o_count); end
  endtask

  task automatic test_fill_drop();
    do_reset();
    bus.enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      bus.i_event = 32'(k);
      tick();
    end
    bus.i_event = '0;
    n_cmp++; if (bus.o_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b exp 1", bus.o_full); end
    n_cmp++; if (bus.o_count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d exp 16", bus.o_count); end
    n_cmp++; if (bus.o_drop_ctr !== 8'd4) begin n_fail++; $display("FAIL fill_drop: got %0d exp 4", bus.o_drop_ctr); end
    bus.i_pop = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      n_cmp++; if (bus.o_event !== 32'(k)) begin n_fail++; $display("FAIL drain_event[%0d]: got %0h exp %0h", k, bus.o_event, k); end
      n_cmp++; if (bus.o_timestamp !== 16'(k - 1)) begin n_fail++; $display("FAIL drain_ts[%0d]: got %0d exp %0d", k, bus.o_timestamp, k - 1); end
      tick();
    end
    bus.i_pop = 1'b0;
    n_cmp++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %0b exp 1", bus.o_empty); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] last_ev;
    do_reset();
    bus.enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.i_event = 32'h100 + 32'(k);
      tick();
    end
    bus.i_event = 32'hAA;
    bus.i_pop   = 1'b1;
    tick();
    bus.i_event = '0;
    n_cmp++; if (bus.o_count !== 5'd16) begin n_fail++; $display("FAIL fpp_count: got %0d exp 16", bus.o_count); end
    n_cmp++; if (bus.o_drop_ctr !== 8'd0) begin n_fail++; $display("FAIL fpp_drop: got %0d exp 0", bus.o_drop_ctr); end
    n_cmp++; if (bus.o_event !== 32'h101) begin n_fail++; $display("FAIL fpp_head: got %0h exp 101", bus.o_event); end
    last_ev = '0;
    for (int k = 0; k < 16; k++) begin
      last_ev = bus.o_event;
      tick();
    end
    bus.i_pop = 1'b0;
    n_cmp++; if (last_ev !== 32'hAA) begin n_fail++; $display("FAIL fpp_last: got %0h exp aa", last_ev); end
    n_cmp++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty: got %0b exp 1", bus.o_empty); end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    bus.enable = 1'b1;
    for (int k = 0; k < 316; k++) begin
      bus.i_event = 32'(k + 1);
      tick();
    end
    n_cmp++; if (bus.o_drop_ctr !== 8'd255) begin n_fail++; $display("FAIL sat_drop: got %0d exp 255", bus.o_drop_ctr); end
    bus.i_event = 32'h55;
    bus.clear   = 1'b1;
    tick();
    bus.clear   = 1'b0;
    bus.i_event = '0;
    n_cmp++; if (bus.o_count !== 5'd0) begin n_fail++; $display("FAIL clr_count: got %0d exp 0", bus.o_count); end
    n_cmp++; if (bus.o_drop_ctr !== 8'd0) begin n_fail++; $display("FAIL clr_drop: got %0d exp 0", bus.o_drop_ctr); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %0b exp 0", bus.o_valid); end
    bus.i_event = 32'h66;
    tick();
    bus.i_event = '0;
    n_cmp++; if (bus.o_timestamp !== 16'd0) begin n_fail++; $display("FAIL clr_ts: got %0d exp 0", bus.o_timestamp); end
    n_cmp++; if (bus.o_event !== 32'h66) begin n_fail++; $display("FAIL clr_event: got %0h exp 66", bus.o_event); end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    bus4.enable = 1'b1;
    repeat (15) tick();
    bus4.i_event = 32'h7;
    tick();
    bus4.i_event = 32'h8;
    tick();
    bus4.i_event = '0;
    bus4.enable  = 1'b0;
    n_cmp++; if (bus4.o_count !== 3'd2) begin n_fail++; $display("FAIL wrap_count: got %0d exp 2", bus4.o_count); end
    n_cmp++; if (bus4.o_event !== 32'h7) begin n_fail++; $display("FAIL wrap_ev0: got %0h exp 7", bus4.o_event); end
    n_cmp++; if (bus4.o_timestamp !== 4'd15) begin n_fail++; $display("FAIL wrap_ts0: got %0d exp 15", bus4.o_timestamp); end
    bus4.i_pop = 1'b1;
    tick();
    bus4.i_pop = 1'b0;
    n_cmp++; if (bus4.o_event !== 32'h8) begin n_fail++; $display("FAIL wrap_ev1: got %0h exp 8", bus4.o_event); end
    n_cmp++; if (bus4.o_timestamp !== 4'd0) begin n_fail++; $display("FAIL wrap_ts1: got %0d exp 0", bus4.o_timestamp); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.i_event = 32'hC0 + 32'(k);
      tick();
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b exp 0", bus.o_valid); end
    n_cmp++; if (bus.o_count !== 5'd0) begin n_fail++; $display("FAIL arst_count: got %0d exp 0", bus.o_count); end
    n_cmp++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL arst_empty: got %0b exp 1", bus.o_empty); end
    n_cmp++; if ({bus.o_event, bus.o_timestamp} !== 48'd0) begin n_fail++; $display("FAIL arst_head: got %0h exp 0", {bus.o_event, bus.o_timestamp}); end
    do_reset();
    bus.enable  = 1'b1;
    bus.i_event = 32'h9;
    tick();
    bus.i_event = '0;
    n_cmp++; if (bus.o_count !== 5'd1) begin n_fail++; $display("FAIL arst_after_count: got %0d exp 1", bus.o_count); end
    n_cmp++; if (bus.o_timestamp !== 16'd0) begin n_fail++; $display("FAIL arst_after_ts: got %0d exp 0", bus.o_timestamp); end
  endtask

  task automatic test_random();
    logic [31:0] exp_ev;
    logic [15:0] exp_ts;
    int          pop_pct;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      pop_pct = (cyc < 400) ? 25 : 70;
      bus.enable  = ($urandom_range(99) < 85);
      bus.clear   = ($urandom_range(99) < 2);
      bus.i_event = ($urandom_range(99) < 30) ? 32'd0 : $urandom();
      bus.i_pop   = ($urandom_range(99) < pop_pct);
      tick();
      exp_ev = (q.size() > 0) ? q[0].ev : 32'd0;
      exp_ts = (q.size() > 0) ? q[0].ts : 16'd0;
      n_cmp++;
      if ({bus.o_valid, bus.o_count, bus.o_full, bus.o_empty, bus.o_drop_ctr} !==
          {(q.size() > 0), 5'(q.size()), (q.size() == 16), (q.size() == 0), 8'(m_drop)}) begin
        n_fail++;
        $display("FAIL rnd_status[%0d]: got cnt=%0d drop=%0d v=%0b f=%0b e=%0b exp cnt=%0d drop=%0d",
                 cyc, bus.o_count, bus.o_drop_ctr, bus.o_valid, bus.o_full, bus.o_empty, q.size(), m_drop);
      end
      n_cmp++;
      if ({bus.o_event, bus.o_timestamp} !== {exp_ev, exp_ts}) begin
        n_fail++;
        $display("FAIL rnd_head[%0d]: got ev=%0h ts=%0d exp ev=%0h ts=%0d",
                 cyc, bus.o_event, bus.o_timestamp, exp_ev, exp_ts);
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_idle_ts();
    test_single_event();
    test_fill_drop();
    test_full_push_pop();
    test_drop_saturate();
    test_ts_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/event_log.md
Name: event_log

Overview:
- Sits directly downstream of the monitor; consumes its per-cycle event word.
- Every non-zero event word is stored with a free-running cycle timestamp in a show-ahead FIFO.
- The host-side register logic pops entries to read back, so each individual event can be inspected in addition to the scoreboard's aggregate count.
- Single clock domain (testbench clock).

Parameters:
- WIDTH, 32, width of event word.
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- TS_WIDTH, 16, timestamp counter width.

Ports:
- clk  input  1  testbench clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  capture enable; also gates the timestamp counter.
- clear  input  1  synchronous flush of FIFO, counters and timestamp.
- i_event  input  WIDTH  event word from monitor; any non-zero value is an event.
- i_pop  input  1  consume head entry.
- o_valid  output  1  head entry present (equals ~o_empty).
- o_event  output  WIDTH  head entry event word.
- o_timestamp  output  TS_WIDTH  head entry timestamp.
- o_count  output  $clog2(DEPTH)+1  entries held.
- o_full  output  1  count == DEPTH.
- o_empty  output  1  count == 0.
- o_drop_ctr  output  8  events lost to a full FIFO; saturating.

Behaviour:
- Reset (reset low, asynchronous): all of the following are 0: pointers, count, timestamp, o_drop_ctr, o_valid, o_event, o_timestamp, o_full. o_empty=1.
- Timestamp: ts increments by 1 each cycle while enable=1; holds while enable=0; wraps 2^TS_WIDTH-1 -> 0.
- Push condition: enable=1 and i_event != 0.
  - Stored entry is {i_event, ts value in that same cycle}.
  - Latency: event sampled at edge n is visible at head (if FIFO was empty) after edge n, i.e. o_valid=1 in cycle n+1.
- Pop condition: i_pop=1 and o_valid=1.
  - Head advances at the edge; the next entry is visible the following cycle.
  - i_pop while empty is ignored; no underflow, no state change.
- Full, push without pop: the entry is dropped; contents unchanged; o_drop_ctr increments, saturating at 255.
- Full, push with pop in the same cycle: both take effect; count stays DEPTH; no drop.
- Empty, push with pop in the same cycle: the pop is ignored (o_valid=0); the push is accepted; count becomes 1.
- Otherwise count changes by +1 on push and -1 on pop.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Count is tracked separately, so full and empty are unambiguous.
- Head outputs are combinational reads of the storage at the read pointer (show-ahead). They hold their value while not popped.
- clear=1 has priority over push and pop in the same cycle. It zeroes pointers, count, ts and o_drop_ctr; o_empty=1 next cycle. Stored data need not be erased.
- Reset asserted mid-operation: immediate return to reset state; no partial entry survives.
- o_full and o_empty are decoded from the registered count (no added latency).

Decomposition:
- Shared package holds:
  - default DEPTH and TS_WIDTH constants;
  - drop-counter width (8) and saturation value (255);
  - the entry layout constant (event field high, timestamp field low, total WIDTH+TS_WIDTH).
- One natural sub-module: sync_fifo (single-clock show-ahead FIFO with count, full, empty).
  - event_log wraps it with the timestamp counter, push qualification, drop counter and clear logic.

Test Plan:
- Reset then 10 cycles with enable=1 and i_event=0 -> o_empty=1, o_count=0; ts internally at 10.
- enable=1 from reset; i_event=32'h0000_0005 at cycle 3 only -> in cycle 4 o_valid=1, o_event=5, o_timestamp=3. Pop in cycle 4 -> o_empty=1 in cycle 5.
- 20 consecutive non-zero events (values 1..20) with no pops, DEPTH=16 -> o_full=1, o_count=16, o_drop_ctr=4. Popping 16 times yields 1..16 in order with consecutive timestamps; then o_empty=1.
- FIFO full; push 32'hAA with pop in the same cycle -> o_count stays 16, o_drop_ctr unchanged; 32'hAA is the last entry read.
- 300 events into a full FIFO -> o_drop_ctr saturates at 255. Assert clear together with a push -> next cycle o_count=0, o_drop_ctr=0, o_valid=0.
- TS_WIDTH=4: events at ts 15 and at the following cycle -> stored timestamps 15 then 0. Assert reset low asynchronously mid-stream -> all outputs at reset values before the next clock edge.
